busline_arbiter: RTL and testbench
==================================

# busline_arbiter

Round-robin arbiter that shares the 10-bit note Busline (bits [9:3] are the seven note LEDs, bits [2:0] the high/low octave field) between three requesters:
- requester 0: live keyboard player
- requester 1: auto-play song engine
- requester 2: learn-mode guide

It sits between those sources and the LED decode stage. It grants one owner at a time, registers the owner's Busline, holds each released note visible for a minimum time, and forces a hand-over when an owner exceeds its ownership budget while others wait.

## Interface
- HOLD_CYCLES, 4: cycles the last Busline value stays visible after release; legal range ≥1.
- MAX_OWN, 8: ownership budget in OWN-state cycles before forced release when another request is pending; legal range ≥1.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  3  request per requester, level-sensitive; bit i = requester i
- bus0  input  10  Busline value from requester 0
- bus1  input  10  Busline value from requester 1
- bus2  input  10  Busline value from requester 2
- grant  output  3  one-hot (or zero) registered grant
- busline_out  output  10  registered Busline to LED decode
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, OWN, GAP. busy = (state != IDLE).
- Reset values (async, immediate):
  - state = IDLE, grant = 0, busline_out = 0
  - round-robin pointer ptr = 2, so the first search order is 0,1,2
  - own_cnt = 0, gap_cnt = 0
- IDLE:
  - grant = 0, busline_out = 0.
  - If req != 0 at an edge, pick winner w = first set bit searching ptr+1, ptr+2, ptr+3 (mod 3).
  - Same edge: grant[w] <= 1, ptr <= w, own_cnt <= 0, state <= OWN.
- OWN:
  - Every edge: busline_out <= bus[w]. own_cnt increments, saturating at MAX_OWN-1.
  - Release condition, evaluated at each edge before the update: req[w] == 0, OR (own_cnt == MAX_OWN-1 AND any other req bit set).
  - On release, same edge: grant <= 0, busline_out keeps its current value (no capture), gap_cnt <= 0, state <= GAP.
  - Owner alone and past budget: stays in OWN indefinitely, own_cnt saturated.
- GAP:
  - grant = 0; busline_out frozen.
  - gap_cnt increments each edge. At the edge where gap_cnt == HOLD_CYCLES-1: busline_out <= 0, state <= IDLE.
  - Requests arriving during GAP are not served until IDLE.
- Simultaneous requests in IDLE: round-robin order only; no fixed priority.
- Owner's bus value changing during OWN: tracked every cycle.
- No preemption except the MAX_OWN budget rule.
- Reset mid-OWN or mid-GAP: all outputs return to reset values immediately; ptr returns to 2.

## Timing
- req rises before edge E in IDLE:
  - grant valid after E.
  - First owner data on busline_out after E+1.
  - Latency req→data: 2 edges.
- Owner drops req before edge R:
  - grant low after R.
  - busline_out holds the value captured at R-1 through edge R+HOLD_CYCLES-1, then reads 0.
- Earliest re-grant: edge R+HOLD_CYCLES+1 (one IDLE cycle).
- Forced release happens at the MAX_OWN-th edge spent in OWN: grant high for exactly MAX_OWN cycles.
- grant and busline_out are both registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use HOLD_CYCLES=4, MAX_OWN=8.

1. **Single short press.** req=3'b001 for 3 cycles, bus0=10'h201.
   - grant=001 from the cycle after req.
   - busline_out=10'h201 from the next cycle.
   - After req drops: grant=000, busline_out stays 10'h201 for 4 cycles, then 10'h000; busy falls with the clear.
2. **Simultaneous requests from reset.** req=3'b011 held; bus0=10'h010, bus1=10'h020; drop req[0] after 5 cycles.
   - grant=001 first.
   - After the 4-cycle gap plus 1 IDLE cycle: grant=010, busline_out=10'h020.
3. **Budget timeout.** req[0] held continuously, req[2] raised at cycle 2.
   - grant=001 for exactly 8 cycles.
   - GAP of 4 with frozen value, then grant=100.
4. **No contention.** req=3'b001 held 20 cycles.
   - grant stays 001 throughout; busline_out tracks bus0 changes with 1-cycle delay.
5. **Round-robin rotation.** req=3'b111 held for 60 cycles.
   - Grant order 001, 010, 100, 001, each lasting 8 cycles, separated by 4-cycle gaps and 1 IDLE cycle.
6. **Asynchronous reset mid-operation.** Assert rst mid-OWN (grant=010), asynchronously between edges.
   - grant=000, busline_out=0, busy=0 immediately.
   - After release with req=3'b111: grant=001 first.

Source files
------------

// File: rtl/busline_arbiter_if.sv
// Busline sharing interface: three requesters on one side, LED decode on the other.
// Latency: none, wires only.
// Backpressure: none; requesters hold req high until they see grant and are done.
interface busline_arbiter_if;
    logic [2:0] req;
    logic [9:0] bus0;
    logic [9:0] bus1;
    logic [9:0] bus2;
    logic [2:0] grant;
    logic [9:0] busline_out;
    logic       busy;

    // Requester/environment side drives requests and note values.
    modport master (
        output req, bus0, bus1, bus2,
        input  grant, busline_out, busy
    );

    // Arbiter side.
    modport slave (
        input  req, bus0, bus1, bus2,
        output grant, busline_out, busy
    );
endinterface

// File: rtl/busline_arbiter.sv
// Round-robin owner of the 10-bit note Busline with post-release hold and ownership budget.
// Latency: grant 1 edge after req, owner data on busline_out 2 edges after req.
// Backpressure: requests wait while another owns the line or its released note is held.
module busline_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_OWN     = 8
) (
    input  logic             clk,
    input  logic             rst,
    busline_arbiter_if.slave bl
);
    localparam int OWN_W = (MAX_OWN > 1) ? $clog2(MAX_OWN) : 1;
    localparam int GAP_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(MAX_OWN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [9:0]         busline_q, busline_d;
    logic [1:0]         ptr_q, ptr_d;      // last winner; during OWN it is the owner
    logic [OWN_W-1:0]   own_cnt_q, own_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               win_vld;
    logic [1:0]         win_idx;
    logic [2:0]         win_oh;
    logic [2:0]         owner_oh;
    logic [9:0]         owner_bus;
    logic               owner_req;
    logic               others_req;
    logic               release_own;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_vld = |bl.req;
        win_idx = 2'd0;
        case (ptr_q)
            2'd0: begin
                if (bl.req[1])      win_idx = 2'd1;
                else if (bl.req[2]) win_idx = 2'd2;
                else                win_idx = 2'd0;
            end
            2'd1: begin
                if (bl.req[2])      win_idx = 2'd2;
                else if (bl.req[0]) win_idx = 2'd0;
                else                win_idx = 2'd1;
            end
            default: begin
                if (bl.req[0])      win_idx = 2'd0;
                else if (bl.req[1]) win_idx = 2'd1;
                else                win_idx = 2'd2;
            end
        endcase
    end

    // Decode winner and current owner; owner is recorded in ptr at grant time.
    always_comb begin
        win_oh    = 3'b000;
        owner_oh  = 3'b000;
        owner_bus = 10'd0;
        case (win_idx)
            2'd0:    win_oh = 3'b001;
            2'd1:    win_oh = 3'b010;
            default: win_oh = 3'b100;
        endcase
        case (ptr_q)
            2'd0: begin
                owner_oh  = 3'b001;
                owner_bus = bl.bus0;
            end
            2'd1: begin
                owner_oh  = 3'b010;
                owner_bus = bl.bus1;
            end
            default: begin
                owner_oh  = 3'b100;
                owner_bus = bl.bus2;
            end
        endcase
        owner_req   = |(bl.req & owner_oh);
        others_req  = |(bl.req & ~owner_oh);
        release_own = !owner_req || ((own_cnt_q == OWN_LAST) && others_req);
    end

    // Next-state and registered-output logic for IDLE / OWN / GAP.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busline_d = busline_q;
        ptr_d     = ptr_q;
        own_cnt_d = own_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d   = 3'b000;
                busline_d = 10'd0;
                if (win_vld) begin
                    grant_d   = win_oh;
                    ptr_d     = win_idx;
                    own_cnt_d = '0;
                    state_d   = ST_OWN;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    // Last captured note stays on the line through the gap.
                    grant_d   = 3'b000;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    busline_d = owner_bus;
                    if (own_cnt_q != OWN_LAST) begin
                        own_cnt_d = own_cnt_q + OWN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                grant_d = 3'b000;
                if (gap_cnt_q == GAP_LAST) begin
                    busline_d = 10'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                grant_d   = 3'b000;
                busline_d = 10'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset points the search at requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            busline_q <= 10'd0;
            ptr_q     <= 2'd2;
            own_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busline_q <= busline_d;
            ptr_q     <= ptr_d;
            own_cnt_q <= own_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bl.grant       = grant_q;
    assign bl.busline_out = busline_q;
    assign bl.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_busline_arbiter.sv
// Bench for busline_arbiter: directed scenarios plus a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_busline_arbiter;
    localparam int HOLD = 4;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    busline_arbiter_if bif ();

    busline_arbiter #(.HOLD_CYCLES(HOLD), .MAX_OWN(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bl  (bif)
    );

    always #5 clk = ~clk;

    // Reference model: owner index, cycles granted so far, hold countdown.
    int         m_owner = -1;
    int         m_last  = 2;
    int         m_owned = 0;
    int         m_gap   = 0;
    logic [9:0] m_bus   = 10'd0;

    function automatic logic [9:0] pick(input int o, input logic [9:0] b0,
                                        input logic [9:0] b1, input logic [9:0] b2);
        if (o == 0) return b0;
        if (o == 1) return b1;
        return b2;
    endfunction

    initial begin
        logic [2:0] others;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = -1;
                m_last  = 2;
                m_owned = 0;
                m_gap   = 0;
                m_bus   = 10'd0;
            end else if (m_owner >= 0) begin
                others = bif.req;
                others[m_owner] = 1'b0;
                if (!bif.req[m_owner] || (m_owned >= MAXO && others != 3'b000)) begin
                    m_owner = -1;
                    m_gap   = HOLD;
                end else begin
                    m_bus   = pick(m_owner, bif.bus0, bif.bus1, bif.bus2);
                    m_owned = m_owned + 1;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_bus = 10'd0;
            end else if (bif.req != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_owner < 0 && bif.req[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
                end
                m_last  = m_owner;
                m_owned = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        logic [2:0] eg;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                eg = 3'b000;
                if (m_owner >= 0) eg[m_owner] = 1'b1;
                chk("model_grant", {7'd0, bif.grant}, {7'd0, eg});
                chk("model_busline", bif.busline_out, m_bus);
                chk("model_busy", {9'd0, bif.busy}, {9'd0, (m_owner >= 0 || m_gap > 0)});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.req = 3'b000;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req  = 3'b000;
        bif.bus0 = 10'd0;
        bif.bus1 = 10'd0;
        bif.bus2 = 10'd0;
        step(2);
        chk("rst_grant", {7'd0, bif.grant}, 10'd0);
        chk("rst_busline", bif.busline_out, 10'd0);
        chk("rst_busy", {9'd0, bif.busy}, 10'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step(1);

        // 1: single short press
        bif.req = 3'b001; bif.bus0 = 10'h201;
        step(1);
        chk("s1_grant", {7'd0, bif.grant}, 10'h001);
        chk("s1_bus_first", bif.busline_out, 10'h000);
        step(1);
        chk("s1_bus_data", bif.busline_out, 10'h201);
        step(1);
        bif.req = 3'b000;
        step(1);
        chk("s1_grant_off", {7'd0, bif.grant}, 10'h000);
        chk("s1_hold0", bif.busline_out, 10'h201);
        step(3);
        chk("s1_hold3", bif.busline_out, 10'h201);
        chk("s1_busy_hold", {9'd0, bif.busy}, 10'd1);
        step(1);
        chk("s1_clear", bif.busline_out, 10'h000);
        chk("s1_busy_clear", {9'd0, bif.busy}, 10'd0);
        step(1);

        // 2: simultaneous requests from reset
        do_reset();
        bif.req = 3'b011; bif.bus0 = 10'h010; bif.bus1 = 10'h020;
        step(1);
        chk("s2_first", {7'd0, bif.grant}, 10'h001);
        step(1);
        chk("s2_bus0", bif.busline_out, 10'h010);
        step(3);
        bif.req = 3'b010;
        step(1);
        chk("s2_release", {7'd0, bif.grant}, 10'h000);
        step(4);
        chk("s2_idle_bus", bif.busline_out, 10'h000);
        step(1);
        chk("s2_second", {7'd0, bif.grant}, 10'h002);
        step(1);
        chk("s2_bus1", bif.busline_out, 10'h020);
        bif.req = 3'b000;
        step(7);

        // 3: budget timeout
        do_reset();
        bif.req = 3'b001; bif.bus0 = 10'h155; bif.bus2 = 10'h0F0;
        step(2);
        bif.req = 3'b101;
        step(6);
        chk("s3_last_own", {7'd0, bif.grant}, 10'h001);
        step(1);
        chk("s3_forced", {7'd0, bif.grant}, 10'h000);
        chk("s3_frozen0", bif.busline_out, 10'h155);
        bif.bus0 = 10'h0AA;
        step(3);
        chk("s3_frozen3", bif.busline_out, 10'h155);
        step(1);
        chk("s3_clear", bif.busline_out, 10'h000);
        step(1);
        chk("s3_next", {7'd0, bif.grant}, 10'h004);
        step(1);
        chk("s3_bus2", bif.busline_out, 10'h0F0);
        bif.req = 3'b000;
        step(7);

        // 4: no contention, bus tracking
        do_reset();
        bif.req = 3'b001;
        for (int i = 0; i < 20; i++) begin
            logic [9:0] v;
            v = 10'(i * 37 + 1);
            bif.bus0 = v;
            step(1);
            chk("s4_grant", {7'd0, bif.grant}, 10'h001);
            if (i >= 1) chk("s4_track", bif.busline_out, v);
        end
        bif.req = 3'b000;
        step(7);

        // 5: round-robin rotation
        do_reset();
        bif.bus0 = 10'h101; bif.bus1 = 10'h202; bif.bus2 = 10'h304;
        bif.req = 3'b111;
        for (int c = 1; c <= 60; c++) begin
            step(1);
            case (c)
                1:  chk("s5_e1", {7'd0, bif.grant}, 10'h001);
                8:  chk("s5_e8", {7'd0, bif.grant}, 10'h001);
                9:  chk("s5_e9", {7'd0, bif.grant}, 10'h000);
                13: chk("s5_e13_busy", {9'd0, bif.busy}, 10'd0);
                14: chk("s5_e14", {7'd0, bif.grant}, 10'h002);
                21: chk("s5_e21", {7'd0, bif.grant}, 10'h002);
                22: chk("s5_e22", {7'd0, bif.grant}, 10'h000);
                27: chk("s5_e27", {7'd0, bif.grant}, 10'h004);
                40: chk("s5_e40", {7'd0, bif.grant}, 10'h001);
                default: ;
            endcase
        end
        bif.req = 3'b000;
        step(14);

        // 6: asynchronous reset mid-OWN
        do_reset();
        bif.req = 3'b111;
        step(16);
        chk("s6_own1", {7'd0, bif.grant}, 10'h002);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_grant", {7'd0, bif.grant}, 10'h000);
        chk("s6_rst_bus", bif.busline_out, 10'h000);
        chk("s6_rst_busy", {9'd0, bif.busy}, 10'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("s6_regrant", {7'd0, bif.grant}, 10'h001);
        step(1);
        chk("s6_bus0", bif.busline_out, 10'h101);
        bif.req = 3'b000;
        step(14);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
